cache_assoc_wb: RTL and testbench

// - Parametrised set-associative, write-back, write-allocate cache that replaces the fixed cache on both the I and D ports of CHIP.
// - Sits between the RISCV_Pipeline word interface and the 128-bit slow memory.
// - Adds configurable set count and associativity (1 or 2 ways), LRU replacement and saturating access/miss statistics counters.

---
 rtl/cache_assoc_wb.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_cache_assoc_wb.sv | 524 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_assoc_wb.sv
// ----------------------------------------------------------------------------
// cache_assoc_wb
//
// Set-associative, write-back, write-allocate cache between the processor word
// interface and a 128-bit block memory. Hits are resolved combinationally, so a
// hit finishes in the same cycle it is presented. Misses go through an optional
// write-back of a dirty victim (WBACK) and then a block refill (ALLOC). When the
// refill completes, the held request hits in IDLE on the following cycle.
//
// Parameters
//   SETS   number of sets (power of 2, 2..64)
//   WAYS   associativity, 1 (direct-mapped) or 2 (LRU replacement)
//   CNT_W  width of the saturating statistics counters
//
// Ports
//   clk, proc_reset                  clock and synchronous active-high reset
//   proc_read, proc_write            word request; write wins if both are set
//   proc_addr[29:0]                  word address {tag, index, word}
//   proc_wdata / proc_rdata          write data / read data (0 when not a read hit)
//   proc_stall                       request not yet complete
//   mem_read, mem_write              registered block requests, never both high
//   mem_addr[27:0]                   block address
//   mem_wdata / mem_rdata            victim block out / refill block in (word 0 in [31:0])
//   mem_ready                        one-cycle completion pulse from memory
//   access_cnt, miss_cnt             saturating completed-access and miss counters
// ----------------------------------------------------------------------------
module cache_assoc_wb #(
    parameter int SETS  = 4,
    parameter int WAYS  = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             proc_reset,
    input  logic             proc_read,
    input  logic             proc_write,
    input  logic [29:0]      proc_addr,
    input  logic [31:0]      proc_wdata,
    output logic [31:0]      proc_rdata,
    output logic             proc_stall,
    output logic             mem_read,
    output logic             mem_write,
    output logic [27:0]      mem_addr,
    output logic [127:0]     mem_wdata,
    input  logic [127:0]     mem_rdata,
    input  logic             mem_ready,
    output logic [CNT_W-1:0] access_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int INDEX_W = $clog2(SETS);
    localparam int TAG_W   = 28 - INDEX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WBACK = 2'd1,
        ALLOC = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    // NOTE: the data and tag arrays have no reset; a line is only ever read
    // through its valid bit, so clearing them would cost logic and buy nothing.
    logic [127:0]     data_q [WAYS][SETS];
    logic [TAG_W-1:0] tag_q  [WAYS][SETS];

    logic [WAYS-1:0][SETS-1:0] valid_q, valid_d;
    logic [WAYS-1:0][SETS-1:0] dirty_q, dirty_d;
    logic [SETS-1:0]           lru_q,   lru_d;   // 1 = way 1 is least recently used

    state_t           state_q,     state_d;
    logic             victim_q,    victim_d;
    logic             mem_read_q,  mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic [27:0]      mem_addr_q,  mem_addr_d;
    logic [127:0]     mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0] access_cnt_q, access_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q,   miss_cnt_d;

    // ------------------------------------------------------------------------
    // Address fields
    // ------------------------------------------------------------------------
    logic [1:0]         req_word;
    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic               request;

    assign req_word  = proc_addr[1:0];
    assign req_index = proc_addr[INDEX_W+1:2];
    assign req_tag   = proc_addr[29:INDEX_W+2];
    assign request   = proc_read | proc_write;

    // During ALLOC, mem_addr_q holds {tag, index} of the block being fetched,
    // so the refill is placed from the registered address, not the live one.
    logic [INDEX_W-1:0] refill_index;
    logic [TAG_W-1:0]   refill_tag;

    assign refill_index = mem_addr_q[INDEX_W-1:0];
    assign refill_tag   = mem_addr_q[27:INDEX_W];

    // ------------------------------------------------------------------------
    // Lookup and victim selection
    // ------------------------------------------------------------------------
    logic         hit;
    logic         hit_way;
    logic [127:0] hit_block;
    logic         victim_sel;
    logic         victim_valid;
    logic         victim_dirty;
    logic [TAG_W-1:0] victim_tag;
    logic [127:0] victim_block;

    // NOTE: every signal assigned in an always_comb gets a default at the top
    // of the block, so no path through it can leave a value held (a latch).
    always_comb begin
        hit       = 1'b0;
        hit_way   = 1'b0;
        hit_block = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][req_index] && (tag_q[w][req_index] == req_tag)) begin
                hit       = 1'b1;
                hit_way   = w[0];
                hit_block = data_q[w][req_index];
            end
        end
    end

    // Invalid ways are preferred over the LRU way; scanning downwards lets way 0
    // win when both are free. With one way, the victim is always way 0.
    always_comb begin
        victim_sel = (WAYS > 1) ? lru_q[req_index] : 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][req_index]) begin
                victim_sel = w[0];
            end
        end

        victim_valid = 1'b0;
        victim_dirty = 1'b0;
        victim_tag   = '0;
        victim_block = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (int'(victim_sel) == w) begin
                victim_valid = valid_q[w][req_index];
                victim_dirty = dirty_q[w][req_index];
                victim_tag   = tag_q[w][req_index];
                victim_block = data_q[w][req_index];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Processor-side outputs
    // ------------------------------------------------------------------------
    logic idle_hit;
    logic hit_we;
    logic refill_we;

    assign idle_hit   = (state_q == IDLE) & hit;
    assign proc_stall = request & ~idle_hit;
    assign proc_rdata = (idle_hit & proc_read & ~proc_write)
                      ? hit_block[{req_word, 5'b0} +: 32] : 32'h0;

    assign hit_we    = idle_hit & proc_write & ~proc_reset;
    assign refill_we = (state_q == ALLOC) & mem_ready & ~proc_reset;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        lru_d        = lru_q;
        access_cnt_d = access_cnt_q;
        miss_cnt_d   = miss_cnt_q;

        if (request && !proc_stall && (access_cnt_q != '1)) begin
            access_cnt_d = access_cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (request && hit) begin
                    if (WAYS > 1) begin
                        lru_d[req_index] = ~hit_way;
                    end
                    for (int w = 0; w < WAYS; w++) begin
                        if (proc_write && (int'(hit_way) == w)) begin
                            dirty_d[w][req_index] = 1'b1;
                        end
                    end
                end else if (request) begin
                    if (miss_cnt_q != '1) begin
                        miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    end
                    victim_d = victim_sel;
                    if (victim_valid && victim_dirty) begin
                        state_d     = WBACK;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {victim_tag, req_index};
                        mem_wdata_d = victim_block;
                    end else begin
                        state_d    = ALLOC;
                        mem_read_d = 1'b1;
                        mem_addr_d = proc_addr[29:2];
                    end
                end
            end

            WBACK: begin
                // Address and data stay frozen until memory accepts the victim;
                // the refill request follows directly, never overlapping.
                if (mem_ready) begin
                    state_d     = ALLOC;
                    mem_write_d = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_addr_d  = proc_addr[29:2];
                end
            end

            ALLOC: begin
                if (mem_ready) begin
                    state_d    = IDLE;
                    mem_read_d = 1'b0;
                    for (int w = 0; w < WAYS; w++) begin
                        if (int'(victim_q) == w) begin
                            valid_d[w][refill_index] = 1'b1;
                            dirty_d[w][refill_index] = 1'b0;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state is assigned with non-blocking (<=) so every flop
    // samples its _d value from before the edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q      <= IDLE;
            victim_q     <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
            lru_q        <= '0;
            access_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            lru_q        <= lru_d;
            access_cnt_q <= access_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // Array write ports: a refill replaces a whole line, a write hit one word.
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (refill_we && (int'(victim_q) == w)) begin
                data_q[w][refill_index] <= mem_rdata;
                tag_q[w][refill_index]  <= refill_tag;
            end else if (hit_we && (int'(hit_way) == w)) begin
                data_q[w][req_index][{req_word, 5'b0} +: 32] <= proc_wdata;
            end
        end
    end

    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign access_cnt = access_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_cache_assoc_wb.sv
// ----------------------------------------------------------------------------
// tb_cache_assoc_wb
//
// Directed bench for cache_assoc_wb (SETS=4, WAYS=2). A second instance with
// CNT_W=4 sees identical stimulus so counter saturation can be observed while
// the main instance keeps exact 16-bit counts. Refill blocks follow a fixed
// pattern: word i of block b is 0xA0000000 | (b << 4) | i.
// ----------------------------------------------------------------------------
module tb_cache_assoc_wb;

    logic         clk = 1'b0;
    logic         proc_reset;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [15:0]  access_cnt;
    logic [15:0]  miss_cnt;

    logic [31:0]  sat_rdata;
    logic         sat_stall;
    logic         sat_mem_read;
    logic         sat_mem_write;
    logic [27:0]  sat_mem_addr;
    logic [127:0] sat_mem_wdata;
    logic [3:0]   sat_access_cnt;
    logic [3:0]   sat_miss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cache_assoc_wb #(.SETS(4), .WAYS(2), .CNT_W(16)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .access_cnt (access_cnt),
        .miss_cnt   (miss_cnt)
    );

    cache_assoc_wb #(.SETS(4), .WAYS(2), .CNT_W(4)) u_sat (
        .clk        (clk),
        .proc_reset (proc_reset),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (sat_rdata),
        .proc_stall (sat_stall),
        .mem_read   (sat_mem_read),
        .mem_write  (sat_mem_write),
        .mem_addr   (sat_mem_addr),
        .mem_wdata  (sat_mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .access_cnt (sat_access_cnt),
        .miss_cnt   (sat_miss_cnt)
    );

    // The two memory request strobes must never overlap.
    always @(negedge clk) begin
        if (proc_reset === 1'b0) begin
            n_checks++;
            if (mem_read === 1'b1 && mem_write === 1'b1) begin
                n_fail++;
                $display("FAIL rd_wr_overlap: got mem_read=1 mem_write=1 expected never both");
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (no comparisons)
    // ------------------------------------------------------------------------
    function automatic logic [127:0] blk(input logic [27:0] a);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*32 +: 32] = 32'hA000_0000 | {a, 4'h0} | 32'(i);
        end
        return r;
    endfunction

    task automatic set_req(input logic rd, input logic wr, input logic [29:0] a,
                           input logic [31:0] wd);
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = a;
        proc_wdata = wd;
    endtask

    task automatic clear_req();
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
    endtask

    // Waits (bounded) for a memory request; returns at negedge + 1.
    task automatic wait_mem(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (mem_read === 1'b1 || mem_write === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Pulses mem_ready for one cycle with the given refill data.
    task automatic serve(input logic [127:0] d);
        mem_rdata = d;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
    endtask

    // Presents a read miss, records the request seen, then refills it after
    // a short memory delay. The request stays asserted on return.
    task automatic do_miss(input logic [29:0] a, output bit ok, output logic seen_rd,
                           output logic seen_wr, output logic [27:0] seen_addr);
        set_req(1'b1, 1'b0, a, 32'h0);
        wait_mem(ok);
        seen_rd   = mem_read;
        seen_wr   = mem_write;
        seen_addr = mem_addr;
        if (ok) begin
            repeat (2) @(negedge clk);
            serve(blk(a[29:2]));
        end
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        proc_reset = 1'b1;
        repeat (3) @(negedge clk);
        proc_reset = 1'b0;
        #1;
        n_checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mem_strobes: got rd=%b wr=%b expected 0 0", mem_read, mem_write);
        end
        n_checks++;
        if (mem_addr !== 28'h0 || mem_wdata !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_mem_bus: got addr=%h wdata=%h expected 0", mem_addr, mem_wdata);
        end
        n_checks++;
        if (access_cnt !== 16'h0 || miss_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_counters: got acc=%0d miss=%0d expected 0 0", access_cnt, miss_cnt);
        end
        n_checks++;
        if (proc_stall !== 1'b0 || proc_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_no_request: got stall=%b rdata=%h expected 0 0", proc_stall, proc_rdata);
        end
    endtask

    task automatic test_cold_read();
        bit ok;
        set_req(1'b1, 1'b0, 30'h10, 32'h0);
        #1;
        n_checks++;
        if (proc_stall !== 1'b1 || proc_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL cold_stall: got stall=%b rdata=%h expected 1 0", proc_stall, proc_rdata);
        end
        wait_mem(ok);
        n_checks++;
        if (!ok || mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 28'h4) begin
            n_fail++;
            $display("FAIL cold_alloc: got ok=%b rd=%b wr=%b addr=%h expected 1 1 0 4",
                     ok, mem_read, mem_write, mem_addr);
        end
        repeat (3) @(negedge clk);
        mem_rdata = blk(28'h4);
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if (mem_read !== 1'b1 || proc_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL cold_hold: got rd=%b stall=%b expected 1 1", mem_read, proc_stall);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (proc_stall !== 1'b0 || proc_rdata !== 32'hA000_0040 || mem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL cold_refill: got stall=%b rdata=%h rd=%b expected 0 a0000040 0",
                     proc_stall, proc_rdata, mem_read);
        end
        @(negedge clk);
        clear_req();
        #1;
        n_checks++;
        if (miss_cnt !== 16'd1 || access_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL cold_counts: got miss=%0d acc=%0d expected 1 1", miss_cnt, access_cnt);
        end
    endtask

    task automatic test_write_hit();
        set_req(1'b0, 1'b1, 30'h11, 32'hDEAD_BEEF);
        #1;
        n_checks++;
        if (proc_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL write_hit_stall: got %b expected 0", proc_stall);
        end
        @(negedge clk);
        set_req(1'b1, 1'b0, 30'h11, 32'h0);
        #1;
        n_checks++;
        if (proc_stall !== 1'b0 || proc_rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL write_readback: got stall=%b rdata=%h expected 0 deadbeef", proc_stall, proc_rdata);
        end
        // Read and write together: the write wins and no data is returned.
        @(negedge clk);
        set_req(1'b1, 1'b1, 30'h12, 32'h1234_5678);
        #1;
        n_checks++;
        if (proc_stall !== 1'b0 || proc_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rw_both: got stall=%b rdata=%h expected 0 0", proc_stall, proc_rdata);
        end
        @(negedge clk);
        set_req(1'b1, 1'b0, 30'h12, 32'h0);
        #1;
        n_checks++;
        if (proc_rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL rw_both_readback: got %h expected 12345678", proc_rdata);
        end
        @(negedge clk);
        clear_req();
        #1;
        n_checks++;
        if (access_cnt !== 16'd5 || miss_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL write_counts: got acc=%0d miss=%0d expected 5 1", access_cnt, miss_cnt);
        end
    endtask

    // Set 0: A=0x10 (way 0), B=0x20, C=0x30.
    task automatic test_lru();
        bit ok;
        logic rd, wr;
        logic [27:0] a;
        do_miss(30'h20, ok, rd, wr, a);
        n_checks++;
        if (!ok || rd !== 1'b1 || wr !== 1'b0 || a !== 28'h8 || proc_rdata !== 32'hA000_0080) begin
            n_fail++;
            $display("FAIL lru_fill_b: got ok=%b rd=%b wr=%b addr=%h rdata=%h expected 1 1 0 8 a0000080",
                     ok, rd, wr, a, proc_rdata);
        end
        @(negedge clk);
        set_req(1'b1, 1'b0, 30'h10, 32'h0);
        #1;
        n_checks++;
        if (proc_stall !== 1'b0 || proc_rdata !== 32'hA000_0040) begin
            n_fail++;
            $display("FAIL lru_touch_a: got stall=%b rdata=%h expected 0 a0000040", proc_stall, proc_rdata);
        end
        @(negedge clk);
        do_miss(30'h30, ok, rd, wr, a);
        n_checks++;
        if (!ok || rd !== 1'b1 || wr !== 1'b0 || a !== 28'hC || proc_rdata !== 32'hA000_00C0) begin
            n_fail++;
            $display("FAIL lru_fill_c: got ok=%b rd=%b wr=%b addr=%h rdata=%h expected 1 1 0 c a00000c0",
                     ok, rd, wr, a, proc_rdata);
        end
        @(negedge clk);
        set_req(1'b1, 1'b0, 30'h10, 32'h0);
        #1;
        n_checks++;
        if (proc_stall !== 1'b0 || proc_rdata !== 32'hA000_0040) begin
            n_fail++;
            $display("FAIL lru_a_kept: got stall=%b rdata=%h expected 0 a0000040", proc_stall, proc_rdata);
        end
        @(negedge clk);
        set_req(1'b1, 1'b0, 30'h11, 32'h0);
        #1;
        n_checks++;
        if (proc_stall !== 1'b0 || proc_rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL lru_a_word1: got stall=%b rdata=%h expected 0 deadbeef", proc_stall, proc_rdata);
        end
        @(negedge clk);
        set_req(1'b1, 1'b0, 30'h20, 32'h0);
        #1;
        n_checks++;
        if (proc_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL lru_b_evicted: got stall=%b expected 1", proc_stall);
        end
        do_miss(30'h20, ok, rd, wr, a);
        n_checks++;
        if (!ok || rd !== 1'b1 || a !== 28'h8 || proc_rdata !== 32'hA000_0080) begin
            n_fail++;
            $display("FAIL lru_refill_b: got ok=%b rd=%b addr=%h rdata=%h expected 1 1 8 a0000080",
                     ok, rd, a, proc_rdata);
        end
        @(negedge clk);
        clear_req();
        #1;
        n_checks++;
        if (miss_cnt !== 16'd4 || access_cnt !== 16'd11) begin
            n_fail++;
            $display("FAIL lru_counts: got miss=%0d acc=%0d expected 4 11", miss_cnt, access_cnt);
        end
    endtask

    // D=0x40 maps to set 0; LRU is way 0 holding dirty A.
    task automatic test_dirty_evict();
        bit ok;
        logic [127:0] victim;
        victim = {32'hA000_0043, 32'h1234_5678, 32'hDEAD_BEEF, 32'hA000_0040};
        set_req(1'b1, 1'b0, 30'h40, 32'h0);
        wait_mem(ok);
        n_checks++;
        if (!ok || mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 28'h4) begin
            n_fail++;
            $display("FAIL wback_start: got ok=%b wr=%b rd=%b addr=%h expected 1 1 0 4",
                     ok, mem_write, mem_read, mem_addr);
        end
        n_checks++;
        if (mem_wdata !== victim) begin
            n_fail++;
            $display("FAIL wback_data: got %h expected %h", mem_wdata, victim);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if ({mem_write, mem_read, mem_addr, mem_wdata} !== {1'b1, 1'b0, 28'h4, victim}) begin
                n_fail++;
                $display("FAIL wback_hold: cycle %0d got wr=%b rd=%b addr=%h wdata=%h", i,
                         mem_write, mem_read, mem_addr, mem_wdata);
            end
        end
        serve(128'h0);
        n_checks++;
        if (mem_write !== 1'b0 || mem_read !== 1'b1 || mem_addr !== 28'h10 || proc_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL wback_to_alloc: got wr=%b rd=%b addr=%h stall=%b expected 0 1 10 1",
                     mem_write, mem_read, mem_addr, proc_stall);
        end
        repeat (2) @(negedge clk);
        serve(blk(28'h10));
        n_checks++;
        if (proc_stall !== 1'b0 || proc_rdata !== 32'hA000_0100) begin
            n_fail++;
            $display("FAIL wback_refill: got stall=%b rdata=%h expected 0 a0000100", proc_stall, proc_rdata);
        end
        @(negedge clk);
        clear_req();
        #1;
        n_checks++;
        if (miss_cnt !== 16'd5 || access_cnt !== 16'd12) begin
            n_fail++;
            $display("FAIL wback_counts: got miss=%0d acc=%0d expected 5 12", miss_cnt, access_cnt);
        end
    endtask

    // 0x50 (block 0x14) misses; reset lands together with its mem_ready.
    task automatic test_reset_mid_alloc();
        bit ok;
        set_req(1'b1, 1'b0, 30'h50, 32'h0);
        wait_mem(ok);
        n_checks++;
        if (!ok || mem_read !== 1'b1 || mem_addr !== 28'h14) begin
            n_fail++;
            $display("FAIL rst_alloc_start: got ok=%b rd=%b addr=%h expected 1 1 14", ok, mem_read, mem_addr);
        end
        @(negedge clk);
        proc_reset = 1'b1;
        mem_rdata  = blk(28'h14);
        mem_ready  = 1'b1;
        @(negedge clk);
        proc_reset = 1'b0;
        mem_ready  = 1'b0;
        #1;
        n_checks++;
        if (mem_read !== 1'b0 || mem_addr !== 28'h0 || proc_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_alloc_abort: got rd=%b addr=%h stall=%b expected 0 0 1",
                     mem_read, mem_addr, proc_stall);
        end
        n_checks++;
        if (miss_cnt !== 16'd0 || access_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_alloc_counts: got miss=%0d acc=%0d expected 0 0", miss_cnt, access_cnt);
        end
        wait_mem(ok);
        n_checks++;
        if (!ok || mem_read !== 1'b1 || mem_addr !== 28'h14) begin
            n_fail++;
            $display("FAIL rst_rereads: got ok=%b rd=%b addr=%h expected 1 1 14", ok, mem_read, mem_addr);
        end
        repeat (2) @(negedge clk);
        serve(blk(28'h14));
        n_checks++;
        if (proc_stall !== 1'b0 || proc_rdata !== 32'hA000_0140) begin
            n_fail++;
            $display("FAIL rst_refill: got stall=%b rdata=%h expected 0 a0000140", proc_stall, proc_rdata);
        end
        @(negedge clk);
        clear_req();
    endtask

    // 19 more misses after the one above: 20 in total since reset.
    task automatic test_saturation();
        bit ok;
        logic rd, wr;
        logic [27:0] a;
        logic [29:0] addr;
        for (int i = 0; i < 19; i++) begin
            addr = 30'h100 + 30'(i * 16);
            do_miss(addr, ok, rd, wr, a);
            n_checks++;
            if (!ok || proc_stall !== 1'b0 || a !== addr[29:2]) begin
                n_fail++;
                $display("FAIL sat_miss: i=%0d got ok=%b stall=%b addr=%h expected 1 0 %h",
                         i, ok, proc_stall, a, addr[29:2]);
            end
            @(negedge clk);
            clear_req();
        end
        #1;
        n_checks++;
        if (miss_cnt !== 16'd20 || access_cnt !== 16'd20) begin
            n_fail++;
            $display("FAIL cnt16_exact: got miss=%0d acc=%0d expected 20 20", miss_cnt, access_cnt);
        end
        n_checks++;
        if (sat_miss_cnt !== 4'hF || sat_access_cnt !== 4'hF) begin
            n_fail++;
            $display("FAIL cnt4_saturate: got miss=%0d acc=%0d expected 15 15", sat_miss_cnt, sat_access_cnt);
        end
    endtask

    // Set 0 now holds blocks 0x84 (addr 0x210) and 0x88 (addr 0x220).
    task automatic test_back_to_back();
        logic [29:0] addrs [4];
        logic [31:0] exp   [4];
        addrs = '{30'h220, 30'h221, 30'h213, 30'h222};
        exp   = '{32'hA000_0880, 32'hA000_0881, 32'hA000_0843, 32'hA000_0882};
        // A stray ready in IDLE must not start anything.
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ready: got rd=%b wr=%b expected 0 0", mem_read, mem_write);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_req(1'b1, 1'b0, addrs[i], 32'h0);
            #1;
            n_checks++;
            if (proc_stall !== 1'b0 || proc_rdata !== exp[i]) begin
                n_fail++;
                $display("FAIL b2b_hit: addr=%h got stall=%b rdata=%h expected 0 %h",
                         addrs[i], proc_stall, proc_rdata, exp[i]);
            end
        end
        @(negedge clk);
        clear_req();
        #1;
        n_checks++;
        if (access_cnt !== 16'd24 || miss_cnt !== 16'd20) begin
            n_fail++;
            $display("FAIL b2b_counts: got acc=%0d miss=%0d expected 24 20", access_cnt, miss_cnt);
        end
    endtask

    initial begin
        proc_reset = 1'b1;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        clear_req();
        test_reset();
        test_cold_read();
        test_write_hit();
        test_lru();
        test_dirty_evict();
        test_reset_mid_alloc();
        test_saturation();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
